// File: rtl/image_capture_pkg.sv
// image_capture_pkg: capture FSM encoding and default bus widths shared with the capture fifo.
package image_capture_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_PIXEL_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FRAME = 2'd1, ACTIVE = 2'd2} state_t;
endpackage

// File: rtl/signal_synchronizer.sv
// signal_synchronizer: 2-FF synchroniser plus one history stage for edge detection.
module signal_synchronizer #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] sync,
  output logic [W-1:0] prev
);
  logic [W-1:0] s1;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) {s1, sync, prev} <= '0;
    else {s1, sync, prev} <= {d, s1, sync};
endmodule

// File: rtl/camera_pixel_packer.sv
// camera_pixel_packer: packs synchronised camera pixels little-endian into fifo words,
// with line/frame markers, drop detection and per-frame/per-line counters.
module camera_pixel_packer import image_capture_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   cam_pclk,
  input  logic                   cam_vsync,
  input  logic                   cam_href,
  input  logic [PIXEL_WIDTH-1:0] cam_data,
  input  logic                   fifo_ready,
  output logic                   push,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   line_end,
  output logic                   frame_done,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] line_count,
  output logic [COUNT_WIDTH-1:0] word_count
);
  localparam int PPW = DATA_WIDTH / PIXEL_WIDTH;
  localparam int IW = PPW > 1 ? $clog2(PPW) : 1;
  state_t state, next_state;
  logic [2:0] ctl, ctl_prev;
  logic [PIXEL_WIDTH-1:0] pixel, pixel_prev_unused;
  logic [DATA_WIDTH-1:0] pack, word_in;
  logic [IW-1:0] pix_idx;
  logic pclk_rise, vsync_rise, vsync_fall, href_fall;
  logic active, start, frame_end, line_fall, pix_in, word_full, flush, emit, drop_partial;
  signal_synchronizer #(.W(3)) u_ctl_sync (
    .clock(clock), .reset_n(reset_n), .d({cam_href, cam_vsync, cam_pclk}),
    .sync(ctl), .prev(ctl_prev)
  );
  signal_synchronizer #(.W(PIXEL_WIDTH)) u_data_sync (
    .clock(clock), .reset_n(reset_n), .d(cam_data),
    .sync(pixel), .prev(pixel_prev_unused)
  );
  assign pclk_rise  = ctl[0] & ~ctl_prev[0];
  assign vsync_rise = ctl[1] & ~ctl_prev[1];
  assign vsync_fall = ~ctl[1] & ctl_prev[1];
  assign href_fall  = ~ctl[2] & ctl_prev[2];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = IDLE;
    if (enable)
      next_state = state == IDLE ? WAIT_FRAME :
                   state == WAIT_FRAME ? (vsync_fall ? ACTIVE : WAIT_FRAME) :
                   state == ACTIVE ? (vsync_rise ? WAIT_FRAME : ACTIVE) : IDLE;
  end
  // End of frame outranks everything else seen in the same cycle.
  assign active       = enable && state == ACTIVE;
  assign start        = enable && state == WAIT_FRAME && vsync_fall;
  assign frame_end    = active && vsync_rise;
  assign line_fall    = active && !vsync_rise && href_fall;
  assign pix_in       = active && !vsync_rise && pclk_rise && ctl[2];
  assign word_full    = pix_in && pix_idx == IW'(PPW - 1);
  assign flush        = line_fall && pix_idx != '0;
  assign emit         = word_full || flush;
  assign drop_partial = !active || vsync_rise || word_full || line_fall;
  assign word_in      = pack | (DATA_WIDTH'(pixel) << (PIXEL_WIDTH * int'(pix_idx)));
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      push       <= 1'b0;
      out_data   <= '0;
      line_end   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      line_count <= '0;
      word_count <= '0;
      pack       <= '0;
      pix_idx    <= '0;
    end else begin
      push       <= emit && fifo_ready;
      line_end   <= line_fall;
      frame_done <= frame_end;
      overflow   <= enable && (overflow || (emit && !fifo_ready));
      if (emit) out_data <= flush ? pack : word_in;
      pack       <= drop_partial ? '0 : pix_in ? word_in : pack;
      pix_idx    <= drop_partial ? '0 : pix_in ? pix_idx + 1'b1 : pix_idx;
      line_count <= start ? '0 : (line_fall && ~&line_count) ? line_count + 1'b1 : line_count;
      word_count <= (start || line_end) ? '0 :
                    (emit && fifo_ready && ~&word_count) ? word_count + 1'b1 : word_count;
    end
endmodule
